// File: rtl/alut_arbiter30_if.sv
// Bundle of the two requester ports and the ALUT APB port seen by alut_arbiter30.
// The master modport is the arbiter's view; slave is the requesters/ALUT side.
interface alut_arbiter30_if;
  logic        req0_30;
  logic        req1_30;
  logic        wr0_30;
  logic        wr1_30;
  logic [6:0]  addr0_30;
  logic [6:0]  addr1_30;
  logic [31:0] wdata0_30;
  logic [31:0] wdata1_30;
  logic        ack0_30;
  logic        ack1_30;
  logic [31:0] rdata0_30;
  logic [31:0] rdata1_30;
  logic        psel30;
  logic        penable30;
  logic        pwrite30;
  logic [6:0]  paddr30;
  logic [31:0] pwdata30;
  logic [31:0] prdata30;
  logic        busy30;

  modport master (
    input  req0_30, req1_30, wr0_30, wr1_30, addr0_30, addr1_30,
           wdata0_30, wdata1_30, prdata30,
    output ack0_30, ack1_30, rdata0_30, rdata1_30, psel30, penable30,
           pwrite30, paddr30, pwdata30, busy30
  );

  modport slave (
    output req0_30, req1_30, wr0_30, wr1_30, addr0_30, addr1_30,
           wdata0_30, wdata1_30, prdata30,
    input  ack0_30, ack1_30, rdata0_30, rdata1_30, psel30, penable30,
           pwrite30, paddr30, pwdata30, busy30
  );
endinterface

// File: rtl/alut_arbiter30.sv
// Round-robin arbiter sharing the ALUT APB port between the host bridge
// (requester 0) and the learning/aging engine (requester 1).
module alut_arbiter30 (
  input  logic             pclk30,
  input  logic             p_reset30,
  alut_arbiter30_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        any_req;
  logic        grant_sel;
  logic        grant;
  logic        last_grant;
  logic        pwrite_q;
  logic [6:0]  paddr_q;
  logic [31:0] pwdata_q;

  assign any_req = bus.req0_30 | bus.req1_30;

  // On a tie the requester that lost the previous arbitration goes next.
  always_comb begin
    grant_sel = 1'b0;
    if (bus.req0_30 && bus.req1_30) begin
      grant_sel = ~last_grant;
    end else if (bus.req1_30) begin
      grant_sel = 1'b1;
    end
  end

  always_ff @(posedge pclk30) begin
    if (p_reset30) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transfer attributes are captured once at grant and left untouched in IDLE.
  always_ff @(posedge pclk30) begin
    if (p_reset30) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      pwrite_q   <= 1'b0;
      paddr_q    <= 7'd0;
      pwdata_q   <= 32'd0;
    end else if (state == IDLE && any_req) begin
      grant      <= grant_sel;
      last_grant <= grant_sel;
      pwrite_q   <= grant_sel ? bus.wr1_30    : bus.wr0_30;
      paddr_q    <= grant_sel ? bus.addr1_30  : bus.addr0_30;
      pwdata_q   <= grant_sel ? bus.wdata1_30 : bus.wdata0_30;
    end
  end

  always_comb begin
    bus.psel30    = 1'b0;
    bus.penable30 = 1'b0;
    bus.ack0_30   = 1'b0;
    bus.ack1_30   = 1'b0;
    case (state)
      SETUP: begin
        bus.psel30 = 1'b1;
      end
      ACCESS: begin
        bus.psel30    = 1'b1;
        bus.penable30 = 1'b1;
        bus.ack0_30   = ~grant;
        bus.ack1_30   = grant;
      end
      default: begin
      end
    endcase
  end

  assign bus.busy30    = (state != IDLE);
  assign bus.pwrite30  = pwrite_q;
  assign bus.paddr30   = paddr_q;
  assign bus.pwdata30  = pwdata_q;
  assign bus.rdata0_30 = bus.ack0_30 ? bus.prdata30 : 32'd0;
  assign bus.rdata1_30 = bus.ack1_30 ? bus.prdata30 : 32'd0;

endmodule

// File: tb/tb_alut_arbiter30.sv
// Bench for alut_arbiter30: directed scenarios then random traffic, all checked
// every cycle against a transaction-timeline model of the arbiter.
module tb_alut_arbiter30;
  logic pclk30    = 1'b0;
  logic p_reset30 = 1'b1;

  alut_arbiter30_if bus();

  alut_arbiter30 dut (
    .pclk30    (pclk30),
    .p_reset30 (p_reset30),
    .bus       (bus.master)
  );

  always #5 pclk30 = ~pclk30;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: a grant at edge g owns the bus during the cycles after edges g and g+1,
  // and the next grant can happen no earlier than edge g+3.
  int          edge_no    = 0;
  int          grant_edge = -10;
  int          next_free  = 0;
  bit          txn_valid  = 1'b0;
  bit          m_who      = 1'b0;
  bit          m_last     = 1'b1;
  bit          m_wr       = 1'b0;
  logic [6:0]  m_addr     = 7'd0;
  logic [31:0] m_wdata    = 32'd0;
  bit          exp_ack0   = 1'b0;
  bit          exp_ack1   = 1'b0;

  bit          rand_prdata = 1'b1;
  logic [31:0] prdata_drv  = 32'd0;
  int          ack_cnt0    = 0;
  int          ack_cnt1    = 0;
  int          both_cnt    = 0;
  bit          renew0      = 1'b0;
  bit          renew1      = 1'b0;
  int          ack_order[$];
  int          ack_ticks[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input bit req, input bit wr,
                               input logic [6:0] addr, input logic [31:0] wdata);
    if (r == 0) begin
      bus.req0_30 = req; bus.wr0_30 = wr; bus.addr0_30 = addr; bus.wdata0_30 = wdata;
    end else begin
      bus.req1_30 = req; bus.wr1_30 = wr; bus.addr1_30 = addr; bus.wdata1_30 = wdata;
    end
  endtask

  task automatic modelSample();
    if (p_reset30) begin
      txn_valid = 1'b0;
      m_last    = 1'b1;
      m_who     = 1'b0;
      next_free = edge_no + 1;
      m_wr      = 1'b0;
      m_addr    = 7'd0;
      m_wdata   = 32'd0;
    end else if (edge_no >= next_free && (bus.req0_30 || bus.req1_30)) begin
      if (bus.req0_30 && bus.req1_30) m_who = !m_last;
      else                            m_who = bus.req1_30;
      m_last     = m_who;
      grant_edge = edge_no;
      next_free  = edge_no + 3;
      txn_valid  = 1'b1;
      m_wr       = m_who ? bus.wr1_30    : bus.wr0_30;
      m_addr     = m_who ? bus.addr1_30  : bus.addr0_30;
      m_wdata    = m_who ? bus.wdata1_30 : bus.wdata0_30;
    end
  endtask

  task automatic checkAll();
    int off;
    bit in_xfer;
    bit acc;
    off      = edge_no - grant_edge;
    in_xfer  = txn_valid && (off == 0 || off == 1);
    acc      = txn_valid && (off == 1);
    exp_ack0 = acc && !m_who;
    exp_ack1 = acc && m_who;
    checkOutput("psel",    32'(bus.psel30),    32'(in_xfer));
    checkOutput("penable", 32'(bus.penable30), 32'(acc));
    checkOutput("busy",    32'(bus.busy30),    32'(in_xfer));
    checkOutput("pwrite",  32'(bus.pwrite30),  32'(m_wr));
    checkOutput("paddr",   32'(bus.paddr30),   32'(m_addr));
    checkOutput("pwdata",  bus.pwdata30,       m_wdata);
    checkOutput("ack0",    32'(bus.ack0_30),   32'(exp_ack0));
    checkOutput("ack1",    32'(bus.ack1_30),   32'(exp_ack1));
    checkOutput("rdata0",  bus.rdata0_30,      exp_ack0 ? prdata_drv : 32'd0);
    checkOutput("rdata1",  bus.rdata1_30,      exp_ack1 ? prdata_drv : 32'd0);
  endtask

  task automatic tick();
    modelSample();
    @(posedge pclk30);
    #1;
    checkAll();
    edge_no++;
    if (bus.ack0_30) begin ack_cnt0++; ack_order.push_back(0); end
    if (bus.ack1_30) begin ack_cnt1++; ack_order.push_back(1); end
    if (bus.ack0_30 && bus.ack1_30) both_cnt++;
    if (rand_prdata) prdata_drv = $urandom;
    bus.prdata30 = prdata_drv;
  endtask

  // Requesters renew (or drop) in the cycle after their ack, otherwise hold.
  task automatic autoStep();
    if (renew0) begin
      renew0 = 1'b0;
      applyStimulus(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    7'($urandom), $urandom);
    end else if (!bus.req0_30 && $urandom_range(0, 3) == 0) begin
      applyStimulus(0, 1'b1, 1'($urandom_range(0, 1)), 7'($urandom), $urandom);
    end
    if (renew1) begin
      renew1 = 1'b0;
      applyStimulus(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    7'($urandom), $urandom);
    end else if (!bus.req1_30 && $urandom_range(0, 3) == 0) begin
      applyStimulus(1, 1'b1, 1'($urandom_range(0, 1)), 7'($urandom), $urandom);
    end
    p_reset30 = ($urandom_range(0, 39) == 0);
    tick();
    if (exp_ack0) renew0 = 1'b1;
    if (exp_ack1) renew1 = 1'b1;
  endtask

  initial begin
    applyStimulus(0, 1'b0, 1'b0, 7'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 7'd0, 32'd0);
    bus.prdata30 = 32'd0;

    // Reset values
    p_reset30 = 1'b1;
    tick();
    tick();
    checkOutput("rst_psel", 32'(bus.psel30), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy30), 32'd0);
    p_reset30 = 1'b0;
    tick();

    // Requester 0 write
    ack_cnt0 = 0;
    applyStimulus(0, 1'b1, 1'b1, 7'h08, 32'h1234_5678);
    tick();
    checkOutput("wr_setup_psel",    32'(bus.psel30),    32'd1);
    checkOutput("wr_setup_penable", 32'(bus.penable30), 32'd0);
    tick();
    checkOutput("wr_access_penable", 32'(bus.penable30), 32'd1);
    checkOutput("wr_access_paddr",   32'(bus.paddr30),   32'h08);
    checkOutput("wr_access_pwdata",  bus.pwdata30,       32'h1234_5678);
    checkOutput("wr_access_ack0",    32'(bus.ack0_30),   32'd1);
    tick();
    checkOutput("wr_done_busy", 32'(bus.busy30), 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 7'd0, 32'd0);
    tick();
    tick();
    checkOutput("wr_ack0_count", 32'(ack_cnt0), 32'd1);

    // Requester 1 read
    rand_prdata = 1'b0;
    prdata_drv  = 32'hDEAD_BEEF;
    bus.prdata30 = prdata_drv;
    ack_cnt1 = 0;
    applyStimulus(1, 1'b1, 1'b0, 7'h10, 32'd0);
    tick();
    checkOutput("rd_setup_rdata1", bus.rdata1_30, 32'd0);
    tick();
    checkOutput("rd_access_rdata1", bus.rdata1_30, 32'hDEAD_BEEF);
    checkOutput("rd_access_rdata0", bus.rdata0_30, 32'd0);
    tick();
    checkOutput("rd_idle_rdata1", bus.rdata1_30, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 7'd0, 32'd0);
    tick();
    tick();
    checkOutput("rd_ack1_count", 32'(ack_cnt1), 32'd1);
    rand_prdata = 1'b1;

    // Both requesters held for eight transfers
    ack_order.delete();
    both_cnt = 0;
    applyStimulus(0, 1'b1, 1'b1, 7'h21, 32'h0000_0A0A);
    applyStimulus(1, 1'b1, 1'b0, 7'h42, 32'h0000_0B0B);
    repeat (24) tick();
    applyStimulus(0, 1'b0, 1'b0, 7'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 7'd0, 32'd0);
    tick();
    tick();
    checkOutput("rr_count", 32'(ack_order.size()), 32'd8);
    for (int k = 0; k < ack_order.size(); k++) begin
      checkOutput($sformatf("rr_order%0d", k), 32'(ack_order[k]), 32'(k % 2));
    end
    checkOutput("rr_both_acks", 32'(both_cnt), 32'd0);

    // Requester 1 arrives during requester 0's ACCESS
    applyStimulus(0, 1'b1, 1'b1, 7'h22, 32'hA5A5_0001);
    tick();
    tick();
    checkOutput("mid_access_paddr", 32'(bus.paddr30), 32'h22);
    applyStimulus(1, 1'b1, 1'b1, 7'h33, 32'h0BAD_F00D);
    tick();
    checkOutput("mid_idle_paddr",  32'(bus.paddr30), 32'h22);
    checkOutput("mid_idle_pwdata", bus.pwdata30,     32'hA5A5_0001);
    applyStimulus(0, 1'b0, 1'b0, 7'd0, 32'd0);
    tick();
    checkOutput("mid_grant1_paddr", 32'(bus.paddr30), 32'h33);
    tick();
    checkOutput("mid_grant1_ack1", 32'(bus.ack1_30), 32'd1);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 7'd0, 32'd0);
    tick();

    // Reset while a write is in flight
    ack_cnt0 = 0;
    applyStimulus(0, 1'b1, 1'b1, 7'h44, 32'hCAFE_0000);
    tick();
    p_reset30 = 1'b1;
    tick();
    checkOutput("rst_mid_psel",    32'(bus.psel30),    32'd0);
    checkOutput("rst_mid_penable", 32'(bus.penable30), 32'd0);
    checkOutput("rst_mid_paddr",   32'(bus.paddr30),   32'd0);
    checkOutput("rst_mid_pwdata",  bus.pwdata30,       32'd0);
    checkOutput("rst_mid_ack0",    32'(ack_cnt0),      32'd0);
    p_reset30 = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 7'h55, 32'd0);
    tick();
    checkOutput("rst_tie_paddr", 32'(bus.paddr30), 32'h44);
    tick();
    checkOutput("rst_tie_ack0", 32'(bus.ack0_30), 32'd1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 7'd0, 32'd0);
    tick();
    tick();
    checkOutput("rst_tie_ack1", 32'(bus.ack1_30), 32'd1);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 7'd0, 32'd0);
    tick();

    // Single requester holding req for three transfers
    ack_ticks.delete();
    applyStimulus(0, 1'b1, 1'b0, 7'h01, 32'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (bus.ack0_30) ack_ticks.push_back(k);
    end
    applyStimulus(0, 1'b0, 1'b0, 7'd0, 32'd0);
    tick();
    tick();
    checkOutput("single_ack_count", 32'(ack_ticks.size()), 32'd3);
    for (int k = 0; k < ack_ticks.size(); k++) begin
      checkOutput($sformatf("single_ack_tick%0d", k), 32'(ack_ticks[k]), 32'(2 + 3 * k));
    end

    // Random traffic with occasional resets
    renew0 = 1'b0;
    renew1 = 1'b0;
    repeat (400) autoStep();
    p_reset30 = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 7'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 7'd0, 32'd0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
